// File: rtl/exec_datapath.sv
// exec_datapath
//   Execute datapath for the simple RISC CPU: register file, A/B/C pipeline
//   registers, B-operand shifter, ALU and an {N,V,Z} status register. An
//   internal sequencer walks each command through IDLE/RDA/RDB/EXE/WB so the
//   controller only issues `start` and waits for `done`.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   command request, sampled only while idle
//   cmd_mode                00 ALU->rd, 01 CMP (flags only), 10 imm->rd, 11 pc+1->rd
//   cmd_aluop               00 add, 01 sub, 10 and, 11 not B
//   cmd_shift               shift on B register: none, LSL1, LSR1, ASR1
//   cmd_asel, cmd_bsel      force A to zero / take B from cmd_imm
//   cmd_rn, cmd_rm, cmd_rd  source A, source B, destination register
//   cmd_imm, pc             immediate and current program counter
//   busy, done              sequencer status (done is a one-cycle pulse)
//   result, flags           C register and {N,V,Z} status register
//   dbg_sel, dbg_data       combinational register-file read port

module exec_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 9,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       cmd_mode,
  input  logic [1:0]       cmd_aluop,
  input  logic [1:0]       cmd_shift,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic [RW-1:0]    cmd_rn,
  input  logic [RW-1:0]    cmd_rm,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [PCW-1:0]   pc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_EXE,
    S_WB
  } state_t;

  state_t state_q, state_d;

  // Latched command fields
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       aluop_q, aluop_d;
  logic [1:0]       shift_q, shift_d;
  logic             asel_q, asel_d;
  logic             bsel_q, bsel_d;
  logic [RW-1:0]    rn_q, rn_d;
  logic [RW-1:0]    rm_q, rm_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [PCW-1:0]   pc_q, pc_d;

  // Datapath state
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [2:0]       flags_q, flags_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand and ALU nets
  logic [WIDTH-1:0] shifted_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [PCW-1:0]   pc_inc;
  logic [WIDTH-1:0] wb_val;

  // Shifter, operand muxes and ALU. V compares operand signs against the
  // result sign; for sub the B operand's sign is effectively inverted.
  always_comb begin
    unique case (shift_q)
      2'b01:   shifted_b = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted_b = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   shifted_b = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: shifted_b = b_q;
    endcase
    op_a = asel_q ? '0 : a_q;
    op_b = bsel_q ? imm_q : shifted_b;
    alu_v = 1'b0;
    unique case (aluop_q)
      2'b00: begin
        alu_res = op_a + op_b;
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b01: begin
        alu_res = op_a - op_b;
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      2'b10:   alu_res = op_a & op_b;
      default: alu_res = ~op_b;
    endcase
  end

  // Writeback source; the link value wraps at the PC width before widening.
  always_comb begin
    pc_inc = pc_q + PCW'(1);
    unique case (mode_q)
      2'b10:   wb_val = imm_q;
      2'b11:   wb_val = WIDTH'(pc_inc);
      default: wb_val = c_q;
    endcase
  end

  // Sequencer next-state and datapath register updates. Sources are read in
  // RDA/RDB, so a destination equal to a source still sees the old value.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    aluop_d = aluop_q;
    shift_d = shift_q;
    asel_d  = asel_q;
    bsel_d  = bsel_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    flags_d = flags_q;
    regs_d  = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = cmd_mode;
          aluop_d = cmd_aluop;
          shift_d = cmd_shift;
          asel_d  = cmd_asel;
          bsel_d  = cmd_bsel;
          rn_d    = cmd_rn;
          rm_d    = cmd_rm;
          rd_d    = cmd_rd;
          imm_d   = cmd_imm;
          pc_d    = pc;
          state_d = cmd_mode[1] ? S_WB : S_RDA;
        end
      end
      S_RDA: begin
        a_d     = regs_q[rn_q];
        state_d = S_RDB;
      end
      S_RDB: begin
        b_d     = regs_q[rm_q];
        state_d = S_EXE;
      end
      S_EXE: begin
        c_d = alu_res;
        if (mode_q[0]) begin
          flags_d = {alu_res[WIDTH-1], alu_v, (alu_res == '0)};
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        regs_d[rd_q] = wb_val;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_WB) || ((state_d == S_EXE) && mode_d[0]);
  end

  // All state; reset aborts any command in flight without a writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      aluop_q <= '0;
      shift_q <= '0;
      asel_q  <= 1'b0;
      bsel_q  <= 1'b0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      regs_q  <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      aluop_q <= aluop_d;
      shift_q <= shift_d;
      asel_q  <= asel_d;
      bsel_q  <= bsel_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = c_q;
  assign flags    = flags_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule
